// File: rtl/rs_encode_stats_log_rd.sv
// rs_encode_stats_log_rd
// Receiving end of the RS-encode stats log interface.
// Every log record is captured into a circular on-chip buffer.
// Indexed reads are served over a val/rdy request/response pair.
// Logical index 0 is always the oldest entry still held.
// The buffer memory is simple dual-port with a registered, read-first read port.
// Optional feature macro: RS_ENC_STATS_LOG_STOP_ON_FULL_EN.
//   When defined, writes are dropped once the buffer is full.
//   In that mode the pointer and contents freeze, and logical == physical index.
// Default record layout (ENTRY_W = 80): rs_enc_stats_struct packs these fields
//   {timestamp[31:0], bytes_sent[31:0], reqs_done[15:0]}.
module rs_encode_stats_log_rd #(
  parameter int LOG_DEPTH_W = 8,
  parameter int ENTRY_W     = 80
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   log_wr_req_val,
  input  logic [ENTRY_W-1:0]     log_wr_req_data,
  input  logic                   rd_req_val,
  input  logic [LOG_DEPTH_W-1:0] rd_req_index,
  output logic                   rd_req_rdy,
  output logic                   rd_resp_val,
  output logic [ENTRY_W-1:0]     rd_resp_data,
  output logic                   rd_resp_err,
  input  logic                   rd_resp_rdy,
  output logic [LOG_DEPTH_W:0]   log_num_entries
);

  localparam int DEPTH = 1 << LOG_DEPTH_W;
  localparam logic [LOG_DEPTH_W:0] DEPTH_CNT = (LOG_DEPTH_W + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_RESP} state_t;

  state_t                 state_reg, state_next;
  logic [ENTRY_W-1:0]     mem [DEPTH];
  logic [ENTRY_W-1:0]     mem_rd_reg;
  logic [LOG_DEPTH_W-1:0] wr_ptr_reg;
  logic [LOG_DEPTH_W:0]   num_entries_reg;
  logic                   err_pend_reg;
  logic                   resp_err_reg;
  logic [ENTRY_W-1:0]     resp_data_reg;

  logic                   full;
  logic                   wr_en;
  logic                   rd_accept;
  logic [LOG_DEPTH_W-1:0] rd_addr;
  logic                   rd_err_next;

  assign full      = (num_entries_reg == DEPTH_CNT);
  assign rd_accept = rd_req_val && (state_reg == ST_IDLE);
  // Out-of-range check is against the entry count before any coincident write.
  assign rd_err_next = ({1'b0, rd_req_index} >= num_entries_reg);

`ifdef RS_ENC_STATS_LOG_STOP_ON_FULL_EN
  // Frozen when full: oldest entry stays at slot 0, so mapping is identity.
  assign wr_en   = log_wr_req_val && !full;
  assign rd_addr = rd_req_index;
`else
  // Once wrapped, the oldest entry sits at wr_ptr; the add wraps mod DEPTH.
  assign wr_en   = log_wr_req_val;
  assign rd_addr = full ? (wr_ptr_reg + rd_req_index) : rd_req_index;
`endif

  // Memory write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= log_wr_req_data;
    end
  end

  // Registered read port; read-first, so a coincident write returns the old slot data.
  always_ff @(posedge clk) begin
    if (rd_accept) begin
      mem_rd_reg <= mem[rd_addr];
    end
  end

  // Write pointer and saturating entry count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      num_entries_reg <= '0;
    end else if (wr_en) begin
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (!full) begin
        num_entries_reg <= num_entries_reg + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic: one request outstanding at a time.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (rd_req_val)  state_next = ST_MEM;
      ST_MEM:                   state_next = ST_RESP;
      ST_RESP: if (rd_resp_rdy) state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    rd_req_rdy  = (state_reg == ST_IDLE);
    rd_resp_val = (state_reg == ST_RESP);
  end

  // Response registers: error flag latched at accept, data captured in MEM and held through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pend_reg  <= 1'b0;
      resp_err_reg  <= 1'b0;
      resp_data_reg <= '0;
    end else begin
      if (rd_accept) begin
        err_pend_reg <= rd_err_next;
      end
      if (state_reg == ST_MEM) begin
        resp_err_reg  <= err_pend_reg;
        resp_data_reg <= err_pend_reg ? '0 : mem_rd_reg;
      end
    end
  end

  assign rd_resp_data    = resp_data_reg;
  assign rd_resp_err     = resp_err_reg;
  assign log_num_entries = num_entries_reg;

endmodule

// File: tb/tb_rs_encode_stats_log_rd.sv
// Directed testbench for rs_encode_stats_log_rd with a 4-entry buffer.
module tb_rs_encode_stats_log_rd;

  localparam int LW = 2;
  localparam int EW = 80;

  logic          clk = 1'b0;
  logic          rst;
  logic          log_wr_req_val;
  logic [EW-1:0] log_wr_req_data;
  logic          rd_req_val;
  logic [LW-1:0] rd_req_index;
  logic          rd_req_rdy;
  logic          rd_resp_val;
  logic [EW-1:0] rd_resp_data;
  logic          rd_resp_err;
  logic          rd_resp_rdy;
  logic [LW:0]   log_num_entries;

  int tests = 0;
  int fails = 0;

  rs_encode_stats_log_rd #(.LOG_DEPTH_W(LW), .ENTRY_W(EW)) dut (
    .clk            (clk),
    .rst            (rst),
    .log_wr_req_val (log_wr_req_val),
    .log_wr_req_data(log_wr_req_data),
    .rd_req_val     (rd_req_val),
    .rd_req_index   (rd_req_index),
    .rd_req_rdy     (rd_req_rdy),
    .rd_resp_val    (rd_resp_val),
    .rd_resp_data   (rd_resp_data),
    .rd_resp_err    (rd_resp_err),
    .rd_resp_rdy    (rd_resp_rdy),
    .log_num_entries(log_num_entries)
  );

  always #5 clk = ~clk;

  // Record built from a timestamp: {timestamp, bytes_sent, reqs_done}.
  function automatic logic [EW-1:0] mk(input logic [31:0] ts);
    logic [15:0] lo;
    lo = ts[15:0] ^ 16'hA5A5;
    return {ts, ts + 32'h0000_1000, lo};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] ts);
    log_wr_req_val  = 1'b1;
    log_wr_req_data = mk(ts);
    step();
    log_wr_req_val  = 1'b0;
    $display("[TB] write ts=%0d num=%0d", ts, log_num_entries);
  endtask

  task automatic check_num(input int exp, input string nm);
    tests++;
    if (log_num_entries !== (LW + 1)'(exp)) begin
      fails++;
      $display("FAIL %s: log_num_entries got %0d expected %0d", nm, log_num_entries, exp);
    end
  endtask

  // Full read transaction; optional write at the accept cycle or during MEM.
  task automatic do_read(input int idx, input logic [31:0] exp_ts, input logic exp_err,
                         input bit wr_at_acc, input bit wr_in_mem, input logic [31:0] wts,
                         input string nm);
    logic [EW-1:0] exp;
    int n;
    exp = exp_err ? '0 : mk(exp_ts);
    tests++;
    if (rd_req_rdy !== 1'b1) begin
      fails++;
      $display("FAIL %s.req_rdy: got %b expected 1", nm, rd_req_rdy);
    end
    rd_resp_rdy  = 1'b1;
    rd_req_val   = 1'b1;
    rd_req_index = LW'(idx);
    if (wr_at_acc) begin
      log_wr_req_val  = 1'b1;
      log_wr_req_data = mk(wts);
    end
    step();
    rd_req_val     = 1'b0;
    log_wr_req_val = 1'b0;
    if (wr_in_mem) begin
      log_wr_req_val  = 1'b1;
      log_wr_req_data = mk(wts);
    end
    n = 1;
    while (rd_resp_val !== 1'b1 && n < 10) begin
      step();
      log_wr_req_val = 1'b0;
      n++;
    end
    log_wr_req_val = 1'b0;
    tests++;
    if (n !== 2) begin
      fails++;
      $display("FAIL %s.latency: got %0d cycles expected 2", nm, n);
    end
    tests++;
    if (rd_resp_data !== exp || rd_resp_err !== exp_err) begin
      fails++;
      $display("FAIL %s.resp: got data=%h err=%b expected data=%h err=%b",
               nm, rd_resp_data, rd_resp_err, exp, exp_err);
    end
    $display("[TB] read %s idx=%0d ts=%0d err=%b", nm, idx, rd_resp_data[79:48], rd_resp_err);
    step();
    tests++;
    if (rd_resp_val !== 1'b0 || rd_req_rdy !== 1'b1) begin
      fails++;
      $display("FAIL %s.idle: got val=%b rdy=%b expected val=0 rdy=1", nm, rd_resp_val, rd_req_rdy);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (rd_req_rdy !== 1'b1 || rd_resp_val !== 1'b0 || rd_resp_err !== 1'b0 || rd_resp_data !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b val=%b err=%b data=%h expected 1 0 0 0",
               rd_req_rdy, rd_resp_val, rd_resp_err, rd_resp_data);
    end
    check_num(0, "reset_num");
    do_read(0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, "empty_idx0");
  endtask

  task automatic test_basic();
    wr(32'd10);
    wr(32'd20);
    wr(32'd30);
    check_num(3, "basic_num");
    do_read(0, 32'd10, 1'b0, 1'b0, 1'b0, 32'd0, "basic_idx0");
    do_read(1, 32'd20, 1'b0, 1'b0, 1'b0, 32'd0, "basic_idx1");
    do_read(2, 32'd30, 1'b0, 1'b0, 1'b0, 32'd0, "basic_idx2");
    do_read(3, 32'd0,  1'b1, 1'b0, 1'b0, 32'd0, "basic_idx3");
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int t = 1; t <= 6; t++) wr(32'(t));
    check_num(4, "wrap_num");
    for (int i = 0; i < 4; i++) begin
`ifdef RS_ENC_STATS_LOG_STOP_ON_FULL_EN
      do_read(i, 32'(i + 1), 1'b0, 1'b0, 1'b0, 32'd0, "stop_idx");
`else
      do_read(i, 32'(i + 3), 1'b0, 1'b0, 1'b0, 32'd0, "wrap_idx");
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] exp;
`ifdef RS_ENC_STATS_LOG_STOP_ON_FULL_EN
    exp = mk(32'd2);
`else
    exp = mk(32'd4);
`endif
    rd_resp_rdy  = 1'b0;
    rd_req_val   = 1'b1;
    rd_req_index = 2'd1;
    step();
    rd_req_val = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (rd_resp_val !== 1'b1 || rd_resp_data !== exp || rd_resp_err !== 1'b0 || rd_req_rdy !== 1'b0) begin
        fails++;
        $display("FAIL hold_c%0d: got val=%b data=%h err=%b rdy=%b expected 1 %h 0 0",
                 c, rd_resp_val, rd_resp_data, rd_resp_err, rd_req_rdy, exp);
      end
      step();
    end
    rd_resp_rdy = 1'b1;
    step();
    tests++;
    if (rd_resp_val !== 1'b0 || rd_req_rdy !== 1'b1) begin
      fails++;
      $display("FAIL hold_release: got val=%b rdy=%b expected val=0 rdy=1", rd_resp_val, rd_req_rdy);
    end
    $display("[TB] backpressure read idx=1 held 5 cycles");
  endtask

  task automatic test_back_to_back();
`ifdef RS_ENC_STATS_LOG_STOP_ON_FULL_EN
    do_read(0, 32'd1, 1'b0, 1'b1, 1'b0, 32'd7, "coinc_acc");
    do_read(0, 32'd1, 1'b0, 1'b0, 1'b1, 32'd8, "coinc_mem");
    do_read(3, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0, "after_idx3");
`else
    do_read(0, 32'd3, 1'b0, 1'b1, 1'b0, 32'd7, "coinc_acc");
    do_read(0, 32'd4, 1'b0, 1'b0, 1'b1, 32'd8, "coinc_mem");
    do_read(3, 32'd8, 1'b0, 1'b0, 1'b0, 32'd0, "after_idx3");
`endif
    check_num(4, "after_num");
  endtask

  task automatic test_reset_in_resp();
    rd_resp_rdy  = 1'b0;
    rd_req_val   = 1'b1;
    rd_req_index = 2'd0;
    step();
    rd_req_val = 1'b0;
    step();
    tests++;
    if (rd_resp_val !== 1'b1) begin
      fails++;
      $display("FAIL rst_resp_pre: got val=%b expected 1", rd_resp_val);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_resp_rdy = 1'b1;
    tests++;
    if (rd_resp_val !== 1'b0 || rd_req_rdy !== 1'b1) begin
      fails++;
      $display("FAIL rst_resp: got val=%b rdy=%b expected val=0 rdy=1", rd_resp_val, rd_req_rdy);
    end
    check_num(0, "rst_resp_num");
    $display("[TB] reset asserted during response");
  endtask

  initial begin
    rst             = 1'b1;
    log_wr_req_val  = 1'b0;
    log_wr_req_data = '0;
    rd_req_val      = 1'b0;
    rd_req_index    = '0;
    rd_resp_rdy     = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_in_resp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
